// File: rtl/grf_multiport_if.sv
// Bus bundle for grf_multiport: two write ports, NR packed read ports and the
// busy flag. The master drives the write and read-address fields, and the slave
// (the register file) returns read data and busy.
interface grf_multiport_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NR = 2
);
    logic             we0;
    logic [AW-1:0]    wa0;
    logic [DW-1:0]    wd0;
    logic [31:0]      pc0;
    logic             we1;
    logic [AW-1:0]    wa1;
    logic [DW-1:0]    wd1;
    logic [31:0]      pc1;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic             busy;

    modport master (
        output we0, wa0, wd0, pc0,
        output we1, wa1, wd1, pc1,
        output ra,
        input  rd, busy
    );

    modport slave (
        input  we0, wa0, wd0, pc0,
        input  we1, wa1, wd1, pc1,
        input  ra,
        output rd, busy
    );
endinterface

// File: rtl/grf_multiport.sv
// grf_multiport: general register file for the pipelined MIPS core.
// NR combinational read ports with write-to-read bypass and two write ports.
// Port 1 wins when both ports write the same address. After reset, the storage
// is cleared by a sequential one-entry-per-cycle sweep, so it can map onto
// RAM-style storage.
// Optional build macro GRF_TRACE_EN prints a trace line for every committed write.
module grf_multiport #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            reset,
    grf_multiport_if.slave  bus
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] LAST_IDX = (AW + 1)'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   idx_q, idx_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic          busy;
    logic          wr0_ok, wr1_ok;
    logic [NR*DW-1:0] rd_c;

    // Control state: synchronous active-low reset restarts the clear sweep
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: advance the sweep and leave CLEAR after the last entry is cleared
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == CLEAR) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
                state_d = READY;
            end
        end
    end

    // Holding reset low also counts as busy, even before the state register has settled
    assign busy   = (state_q == CLEAR) || !reset;
    assign wr0_ok = !busy && bus.we0 && !((ZERO_REG != 0) && (bus.wa0 == '0));
    assign wr1_ok = !busy && bus.we1 && !((ZERO_REG != 0) && (bus.wa1 == '0));

    // Storage: clear sweep while busy, and commit writes when ready (port 1 assigned last, so it wins)
    always_ff @(posedge clk) begin
        if (reset && (state_q == CLEAR)) begin
            mem_q[idx_q[AW-1:0]] <= '0;
        end
        if (wr0_ok) begin
            mem_q[bus.wa0] <= bus.wd0;
        end
        if (wr1_ok) begin
            mem_q[bus.wa1] <= bus.wd1;
        end
    end

    // Read ports: zero while busy, bypass in commit priority order, then storage
    always_comb begin
        rd_c = '0;
        for (int k = 0; k < NR; k++) begin
            if (!busy && !((ZERO_REG != 0) && (bus.ra[k*AW +: AW] == '0))) begin
                if (bus.we1 && (bus.wa1 == bus.ra[k*AW +: AW])) begin
                    rd_c[k*DW +: DW] = bus.wd1;
                end else if (bus.we0 && (bus.wa0 == bus.ra[k*AW +: AW])) begin
                    rd_c[k*DW +: DW] = bus.wd0;
                end else begin
                    rd_c[k*DW +: DW] = mem_q[bus.ra[k*AW +: AW]];
                end
            end
        end
    end

    assign bus.rd   = rd_c;
    assign bus.busy = busy;

`ifdef GRF_TRACE_EN
    // Commit trace: port 0 first, and port 0 is suppressed when port 1 overwrites the same entry
    always_ff @(posedge clk) begin
        if (wr0_ok && !(wr1_ok && (bus.wa1 == bus.wa0))) begin
            $display("%d@%h: $%d <= %h", $time, bus.pc0, bus.wa0, bus.wd0);
        end
        if (wr1_ok) begin
            $display("%d@%h: $%d <= %h", $time, bus.pc1, bus.wa1, bus.wd1);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^{bus.pc0, bus.pc1};
`endif

endmodule

// File: tb/tb_grf_multiport.sv
// Testbench for grf_multiport. It uses two instances:
//   dut_a: NR=4, ZERO_REG=1
//   dut_b: NR=2, ZERO_REG=0
// Both instances share clock, reset and the write stimulus.
module tb_grf_multiport;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    grf_multiport_if #(.DW(32), .AW(5), .NR(4)) ia ();
    grf_multiport_if #(.DW(32), .AW(5), .NR(2)) ib ();

    grf_multiport #(.DW(32), .AW(5), .NR(4), .ZERO_REG(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia.slave)
    );

    grf_multiport #(.DW(32), .AW(5), .NR(2), .ZERO_REG(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural model: cycles of clearing still to go, plus the visible register contents
    int          rem = 32;
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];

    always @(posedge clk) begin
        if (!reset) begin
            rem <= 32;
            for (int i = 0; i < 32; i++) begin
                mem_a[i] <= 32'h0;
                mem_b[i] <= 32'h0;
            end
        end else if (rem > 0) begin
            rem <= rem - 1;
        end else begin
            if (ia.we0 && ia.wa0 != 5'd0) mem_a[ia.wa0] <= ia.wd0;
            if (ia.we1 && ia.wa1 != 5'd0) mem_a[ia.wa1] <= ia.wd1;
            if (ib.we0) mem_b[ib.wa0] <= ib.wd0;
            if (ib.we1) mem_b[ib.wa1] <= ib.wd1;
        end
    end

    function automatic logic [31:0] exp_rd(input bit bz, input bit zr, input logic [31:0] stored,
                                           input logic [4:0] addr,
                                           input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                                           input logic w1, input logic [4:0] a1, input logic [31:0] d1);
        if (bz) return 32'h0;
        if (zr && addr == 5'd0) return 32'h0;
        if (w1 && a1 == addr) return d1;
        if (w0 && a0 == addr) return d0;
        return stored;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
        end
    endtask

    // Every-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        bit bz;
        if (chk_en) begin
            bz = !reset || (rem > 0);
            cmp("busy_a", {31'b0, ia.busy}, {31'b0, bz});
            cmp("busy_b", {31'b0, ib.busy}, {31'b0, bz});
            for (int k = 0; k < 4; k++) begin
                logic [4:0] a;
                a = ia.ra[k*5 +: 5];
                cmp($sformatf("rd_a%0d", k), ia.rd[k*32 +: 32],
                    exp_rd(bz, 1'b1, mem_a[a], a, ia.we0, ia.wa0, ia.wd0, ia.we1, ia.wa1, ia.wd1));
            end
            for (int k = 0; k < 2; k++) begin
                logic [4:0] a;
                a = ib.ra[k*5 +: 5];
                cmp($sformatf("rd_b%0d", k), ib.rd[k*32 +: 32],
                    exp_rd(bz, 1'b0, mem_b[a], a, ib.we0, ib.wa0, ib.wd0, ib.we1, ib.wa1, ib.wd1));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic w1, input logic [4:0] a1, input logic [31:0] d1);
        ia.we0 = w0; ia.wa0 = a0; ia.wd0 = d0;
        ia.we1 = w1; ia.wa1 = a1; ia.wd1 = d1;
        ib.we0 = w0; ib.wa0 = a0; ib.wd0 = d0;
        ib.we1 = w1; ib.wa1 = a1; ib.wd1 = d1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!ia.busy) break;
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0;
        set_w(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        ia.pc0 = 32'h0; ia.pc1 = 32'h0; ib.pc0 = 32'h0; ib.pc1 = 32'h0;
        ia.ra = '0;
        ib.ra = '0;

        // Hold reset for 3 cycles, then time the clear sweep
        repeat (3) step();
        chk_en = 1'b1;
        reset = 1'b1;
        count_busy(n);
        cmp("sweep_len", 32'(n), 32'd32);
        cmp("busy_b_after_sweep", {31'b0, ib.busy}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            step();
            ia.ra = {4{5'(i)}};
            ib.ra = {2{5'(i)}};
            @(negedge clk);
            cmp("clear_a", ia.rd[31:0], 32'h0);
            cmp("clear_b", ib.rd[63:32], 32'h0);
        end

        // Same-cycle bypass, then the committed value
        step();
        set_w(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        ia.ra = {5'd0, 5'd0, 5'd0, 5'd5};
        @(negedge clk);
        cmp("bypass_5", ia.rd[31:0], 32'hDEADBEEF);
        step();
        set_w(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        cmp("stored_5", ia.rd[31:0], 32'hDEADBEEF);

        // Both ports write the same address, and port 1 wins
        step();
        set_w(1'b1, 5'd7, 32'h1111, 1'b1, 5'd7, 32'h2222);
        ia.ra = {5'd0, 5'd0, 5'd7, 5'd0};
        @(negedge clk);
        cmp("collide_byp", ia.rd[63:32], 32'h2222);
        step();
        set_w(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        cmp("collide_st", ia.rd[63:32], 32'h2222);

        // Entry 0 behaviour with ZERO_REG=1 (a) and ZERO_REG=0 (b)
        step();
        set_w(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        ia.ra = '0;
        ib.ra = '0;
        @(negedge clk);
        cmp("zr1_byp", ia.rd[31:0], 32'h0);
        cmp("zr0_byp", ib.rd[31:0], 32'hFFFF_FFFF);
        step();
        set_w(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        cmp("zr1_st", ia.rd[31:0], 32'h0);
        cmp("zr0_st", ib.rd[31:0], 32'hFFFF_FFFF);

        // Four read ports, including a repeated address and entry 0
        step();
        ia.pc0 = 32'h3000;
        set_w(1'b1, 5'd3, 32'h12, 1'b0, 5'd0, 32'h0);
        step();
        set_w(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        ia.ra = {5'd3, 5'd3, 5'd0, 5'd1};
        @(negedge clk);
        cmp("nr4_rd", ia.rd[127:96], 32'h12);
        cmp("nr4_rd", ia.rd[95:64], 32'h12);
        cmp("nr4_rd", ia.rd[63:32], 32'h0);
        cmp("nr4_rd", ia.rd[31:0], 32'h0);

        // A reset in the middle of the sweep restarts it, and writes while busy are dropped
        step();
        set_w(1'b1, 5'd9, 32'hABCD, 1'b0, 5'd0, 32'h0);
        step();
        set_w(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        ia.ra = {5'd0, 5'd0, 5'd0, 5'd9};
        @(negedge clk);
        cmp("pre_9", ia.rd[31:0], 32'hABCD);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        set_w(1'b1, 5'd9, 32'h5555, 1'b1, 5'd10, 32'h6666);
        repeat (9) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        set_w(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        count_busy(n);
        cmp("resweep_len", 32'(n), 32'd32);
        step();
        ia.ra = {5'd0, 5'd10, 5'd3, 5'd9};
        @(negedge clk);
        cmp("post_9", ia.rd[31:0], 32'h0);
        cmp("post_3", ia.rd[63:32], 32'h0);
        cmp("post_10", ia.rd[95:64], 32'h0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
